wb_queue: RTL and testbench
===========================

WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 Parameter: DEPTH, 4, FIFO entries; power of two, at least 2.
REQ-002 clock  in  1  sole clock; all state changes on its rising edge.
REQ-003 ctrl_reset  in  1  synchronous, active-low reset (0 = reset).
REQ-004 in_valid_a / in_valid_b  in  1 each  result valid; slot b is younger than slot a in the same cycle.
REQ-005 in_rd_a / in_rd_b  in  5 each  destination register.
REQ-006 in_data_a / in_data_b  in  32 each  result data.
REQ-007 in_ready  out  1  high when at least 2 entries are free.
REQ-008 drain_en  in  1  when low, nothing is popped or written.
REQ-009 ctrl_writeEnable_a / ctrl_writeEnable_b  out  1 each  register file write enables.
REQ-010 ctrl_writeReg_a / ctrl_writeReg_b  out  5 each  register file write addresses.
REQ-011 data_writeReg_a / data_writeReg_b  out  32 each  register file write data.
REQ-012 byp_addr_0..3  in  5 each  read-address lookup (one per register-file read port).
REQ-013 byp_hit_0..3  out  1 each  lookup hit flag.
REQ-014 byp_data_0..3  out  32 each  lookup data.

Function
REQ-015 Push: a slot is accepted only when in_ready=1, its valid=1 and its rd!=0; rd=0 slots are discarded silently.
REQ-016 in_ready depends only on the registered occupancy count (no combinational path from drain_en or the input valids).
REQ-017 Both slots accepted: a is enqueued before b. Only b valid: b takes the next single entry.
REQ-018 Write ports are combinational from the FIFO head: port a carries the oldest entry (head0), port b the next oldest (head1).
REQ-019 When drain_en=1: the enable for a port is high iff its entry exists; 2 entries pop if count>=2, 1 entry if count=1.
REQ-020 If head0.rd==head1.rd and both are driven: ctrl_writeEnable_a=0, ctrl_writeEnable_b=1, and both entries pop (younger wins).
REQ-021 Latency: an entry pushed at edge N appears on a write port during the cycle after N at the earliest, and commits at the next edge with drain_en=1.
REQ-022 Simultaneous push and pop in one cycle are legal; count_next = count + pushed - popped; pointers wrap modulo DEPTH.
REQ-023 Empty: both enables are 0 and the address/data outputs are 0.
REQ-024 Full: in_ready=0 and inputs are ignored; draining continues.
REQ-025 Lookup: a hit is the youngest valid entry whose rd equals byp_addr; byp_data is that entry's data. byp_addr=0 never hits.

Reset
REQ-026 ctrl_reset=0 at an edge clears count and pointers. Outputs then read: in_ready=1, all enables 0, all address/data outputs 0, all byp_hit 0.
REQ-027 Reset mid-operation discards all queued entries; no write enable is asserted in the cycle following the reset edge.
REQ-028 Entry storage is not cleared by reset; only valid state is reset.

Configuration
REQ-029 Macro WBQ_BYPASS_EN defined: the lookup logic of REQ-025 is compiled in.
REQ-030 WBQ_BYPASS_EN undefined: the byp_* ports remain, byp_hit_* are tied to 0, byp_data_* are tied to 0, and no match logic is built.

Structure
REQ-031 Shared package wb_pkg holds the DEPTH default, the REG_W=5 and DATA_W=32 constants, and the entry typedef {rd, data}.
REQ-032 Sub-module wbq_match (one lookup port, youngest-match priority over DEPTH entries) is instantiated 4 times under WBQ_BYPASS_EN.

Verification
REQ-033 Reset, then push a=(r3,0x11), b=(r4,0x22) with drain_en=1 -> next cycle: port a = r3/0x11 and port b = r4/0x22 both enabled, and the queue is empty after the edge.
REQ-034 drain_en=0; push 2 pairs -> in_ready=0 after the 2nd pair and a 3rd pair is ignored; set drain_en=1 -> 2 cycles of dual writes in order.
REQ-035 Push a=(r5,0xA), b=(r5,0xB) -> ctrl_writeEnable_a=0, port b writes r5=0xB, and both entries pop.
REQ-036 Push a=(r0,0x1), b=(r7,0x2) -> only r7 is enqueued and appears on port a; count=1.
REQ-037 WBQ_BYPASS_EN, drain_en=0, queue holds r9=0x1 then r9=0x2; byp_addr_0=9 -> byp_hit_0=1, byp_data_0=0x2. Without the macro -> byp_hit_0=0.
REQ-038 Fill to 3 entries, assert ctrl_reset=0 for one edge -> count=0, no enables next cycle, in_ready=1.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants and entry type for the write-back queue.
package wb_pkg;

  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned DATA_W    = 32;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/wbq_match.sv
// One bypass lookup port: youngest queued entry whose rd equals addr.
// Only compiled when WBQ_BYPASS_EN is defined, since nothing else uses it.
`ifdef WBQ_BYPASS_EN
module wbq_match
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  entry_t [DEPTH-1:0]         entries,
  input  logic [$clog2(DEPTH)-1:0]   rd_ptr,
  input  logic [$clog2(DEPTH):0]     count,
  input  logic [REG_W-1:0]           addr,
  output logic                       hit,
  output logic [DATA_W-1:0]          data
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  // Walk from oldest to youngest so a later (younger) match overrides.
  always_comb begin
    logic [PW-1:0] idx;
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if ((CW'(k) < count) && (entries[idx].rd == addr) && (addr != '0)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule
`endif

// File: rtl/wb_queue.sv
// Dual-slot write-back FIFO feeding two register-file write ports, with
// optional read-port bypass lookup compiled in by WBQ_BYPASS_EN.
module wb_queue
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              in_valid_a,
  input  logic              in_valid_b,
  input  logic [REG_W-1:0]  in_rd_a,
  input  logic [REG_W-1:0]  in_rd_b,
  input  logic [DATA_W-1:0] in_data_a,
  input  logic [DATA_W-1:0] in_data_b,
  output logic              in_ready,
  input  logic              drain_en,
  output logic              ctrl_writeEnable_a,
  output logic              ctrl_writeEnable_b,
  output logic [REG_W-1:0]  ctrl_writeReg_a,
  output logic [REG_W-1:0]  ctrl_writeReg_b,
  output logic [DATA_W-1:0] data_writeReg_a,
  output logic [DATA_W-1:0] data_writeReg_b,
  input  logic [REG_W-1:0]  byp_addr_0,
  input  logic [REG_W-1:0]  byp_addr_1,
  input  logic [REG_W-1:0]  byp_addr_2,
  input  logic [REG_W-1:0]  byp_addr_3,
  output logic              byp_hit_0,
  output logic              byp_hit_1,
  output logic              byp_hit_2,
  output logic              byp_hit_3,
  output logic [DATA_W-1:0] byp_data_0,
  output logic [DATA_W-1:0] byp_data_1,
  output logic [DATA_W-1:0] byp_data_2,
  output logic [DATA_W-1:0] byp_data_3
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  entry_t     head0, head1;
  logic       has0, has1, dup;
  logic       acc_a, acc_b;
  logic [1:0] pop_n;

  assign in_ready = (count_q <= CW'(DEPTH - 2));

  // Head view, write-port drive and pop amount; a same-rd pair collapses to port b.
  always_comb begin
    head0 = mem_q[rd_ptr_q];
    head1 = mem_q[rd_ptr_q + 1'b1];
    has0  = (count_q != '0);
    has1  = (count_q >= CW'(2));
    dup   = has1 && (head0.rd == head1.rd);

    ctrl_writeEnable_a = drain_en && has0 && !dup;
    ctrl_writeEnable_b = drain_en && has1;
    ctrl_writeReg_a    = has0 ? head0.rd   : '0;
    data_writeReg_a    = has0 ? head0.data : '0;
    ctrl_writeReg_b    = has1 ? head1.rd   : '0;
    data_writeReg_b    = has1 ? head1.data : '0;

    pop_n = 2'd0;
    if (drain_en) begin
      if (has1)      pop_n = 2'd2;
      else if (has0) pop_n = 2'd1;
    end
  end

  // Push path: slot a before slot b, rd=0 slots dropped; pointer/count update.
  always_comb begin
    logic [PW-1:0] wp;
    acc_a = in_ready && in_valid_a && (in_rd_a != '0);
    acc_b = in_ready && in_valid_b && (in_rd_b != '0);
    mem_d = mem_q;
    wp    = wr_ptr_q;
    if (acc_a) begin
      mem_d[wp] = '{rd: in_rd_a, data: in_data_a};
      wp        = wp + 1'b1;
    end
    if (acc_b) begin
      mem_d[wp] = '{rd: in_rd_b, data: in_data_b};
      wp        = wp + 1'b1;
    end
    wr_ptr_d = wp;
    rd_ptr_d = rd_ptr_q + PW'(pop_n);
    count_d  = count_q + CW'(acc_a) + CW'(acc_b) - CW'(pop_n);
  end

  // Occupancy and pointers, synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is left untouched by reset; validity comes from count.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

`ifdef WBQ_BYPASS_EN
  entry_t [DEPTH-1:0] entries_flat;
  logic [REG_W-1:0]   byp_addr [4];
  logic               byp_hit  [4];
  logic [DATA_W-1:0]  byp_data [4];

  // Flatten storage for the lookup ports.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) entries_flat[i] = mem_q[i];
  end

  assign byp_addr[0] = byp_addr_0;
  assign byp_addr[1] = byp_addr_1;
  assign byp_addr[2] = byp_addr_2;
  assign byp_addr[3] = byp_addr_3;

  for (genvar p = 0; p < 4; p++) begin : g_match
    wbq_match #(.DEPTH(DEPTH)) u_match (
      .entries (entries_flat),
      .rd_ptr  (rd_ptr_q),
      .count   (count_q),
      .addr    (byp_addr[p]),
      .hit     (byp_hit[p]),
      .data    (byp_data[p])
    );
  end

  assign byp_hit_0  = byp_hit[0];
  assign byp_hit_1  = byp_hit[1];
  assign byp_hit_2  = byp_hit[2];
  assign byp_hit_3  = byp_hit[3];
  assign byp_data_0 = byp_data[0];
  assign byp_data_1 = byp_data[1];
  assign byp_data_2 = byp_data[2];
  assign byp_data_3 = byp_data[3];
`else
  logic unused_byp;
  assign unused_byp = ^{byp_addr_0, byp_addr_1, byp_addr_2, byp_addr_3};
  assign byp_hit_0  = 1'b0;
  assign byp_hit_1  = 1'b0;
  assign byp_hit_2  = 1'b0;
  assign byp_hit_3  = 1'b0;
  assign byp_data_0 = '0;
  assign byp_data_1 = '0;
  assign byp_data_2 = '0;
  assign byp_data_3 = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue (DEPTH=4), with or without WBQ_BYPASS_EN.
module tb_wb_queue;
  import wb_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic              clock, ctrl_reset, drain_en;
  logic              in_valid_a, in_valid_b, in_ready;
  logic [REG_W-1:0]  in_rd_a, in_rd_b;
  logic [DATA_W-1:0] in_data_a, in_data_b;
  logic              ctrl_writeEnable_a, ctrl_writeEnable_b;
  logic [REG_W-1:0]  ctrl_writeReg_a, ctrl_writeReg_b;
  logic [DATA_W-1:0] data_writeReg_a, data_writeReg_b;
  logic [REG_W-1:0]  byp_addr_0, byp_addr_1, byp_addr_2, byp_addr_3;
  logic              byp_hit_0, byp_hit_1, byp_hit_2, byp_hit_3;
  logic [DATA_W-1:0] byp_data_0, byp_data_1, byp_data_2, byp_data_3;

  int errors = 0;
  int checks = 0;
  entry_t sb[$];

  wb_queue #(.DEPTH(DEPTH)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .in_valid_a(in_valid_a), .in_valid_b(in_valid_b),
    .in_rd_a(in_rd_a), .in_rd_b(in_rd_b),
    .in_data_a(in_data_a), .in_data_b(in_data_b),
    .in_ready(in_ready), .drain_en(drain_en),
    .ctrl_writeEnable_a(ctrl_writeEnable_a), .ctrl_writeEnable_b(ctrl_writeEnable_b),
    .ctrl_writeReg_a(ctrl_writeReg_a), .ctrl_writeReg_b(ctrl_writeReg_b),
    .data_writeReg_a(data_writeReg_a), .data_writeReg_b(data_writeReg_b),
    .byp_addr_0(byp_addr_0), .byp_addr_1(byp_addr_1),
    .byp_addr_2(byp_addr_2), .byp_addr_3(byp_addr_3),
    .byp_hit_0(byp_hit_0), .byp_hit_1(byp_hit_1),
    .byp_hit_2(byp_hit_2), .byp_hit_3(byp_hit_3),
    .byp_data_0(byp_data_0), .byp_data_1(byp_data_1),
    .byp_data_2(byp_data_2), .byp_data_3(byp_data_3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic va, input logic [4:0] ra, input logic [31:0] da,
                        input logic vb, input logic [4:0] rb, input logic [31:0] db);
    in_valid_a = va; in_rd_a = ra; in_data_a = da;
    in_valid_b = vb; in_rd_b = rb; in_data_b = db;
  endtask

  task automatic test_reset();
    ctrl_reset = 1'b0; drain_en = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    byp_addr_0 = 0; byp_addr_1 = 0; byp_addr_2 = 0; byp_addr_3 = 0;
    tick(); tick();
    ctrl_reset = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b want=1", in_ready); end
    checks++; if ({ctrl_writeEnable_a, ctrl_writeEnable_b} !== 2'b00) begin errors++; $display("FAIL reset_we got=%b want=00", {ctrl_writeEnable_a, ctrl_writeEnable_b}); end
    checks++; if ({ctrl_writeReg_a, ctrl_writeReg_b, data_writeReg_a, data_writeReg_b} !== '0) begin errors++; $display("FAIL reset_addr_data got=%h want=0", {ctrl_writeReg_a, ctrl_writeReg_b, data_writeReg_a, data_writeReg_b}); end
    checks++; if ({byp_hit_0, byp_hit_1, byp_hit_2, byp_hit_3} !== 4'b0000) begin errors++; $display("FAIL reset_byp_hit got=%b want=0000", {byp_hit_0, byp_hit_1, byp_hit_2, byp_hit_3}); end
  endtask

  task automatic test_dual_push();
    drain_en = 1'b1;
    set_in(1, 5'd3, 32'h11, 1, 5'd4, 32'h22);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    checks++; if ({ctrl_writeEnable_a, ctrl_writeEnable_b} !== 2'b11) begin errors++; $display("FAIL dual_we got=%b want=11", {ctrl_writeEnable_a, ctrl_writeEnable_b}); end
    checks++; if ({ctrl_writeReg_a, data_writeReg_a} !== {5'd3, 32'h11}) begin errors++; $display("FAIL dual_port_a got=%0d/%h want=3/11", ctrl_writeReg_a, data_writeReg_a); end
    checks++; if ({ctrl_writeReg_b, data_writeReg_b} !== {5'd4, 32'h22}) begin errors++; $display("FAIL dual_port_b got=%0d/%h want=4/22", ctrl_writeReg_b, data_writeReg_b); end
    tick();
    checks++; if ({ctrl_writeEnable_a, ctrl_writeEnable_b, ctrl_writeReg_a} !== '0) begin errors++; $display("FAIL dual_empty_after got=%b/%0d want=00/0", {ctrl_writeEnable_a, ctrl_writeEnable_b}, ctrl_writeReg_a); end
  endtask

  task automatic test_full();
    entry_t ea, eb;
    drain_en = 1'b0;
    set_in(1, 5'd1, 32'h101, 1, 5'd2, 32'h102);
    sb.push_back('{rd: 5'd1, data: 32'h101}); sb.push_back('{rd: 5'd2, data: 32'h102});
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_two got=%0b want=1", in_ready); end
    set_in(1, 5'd3, 32'h103, 1, 5'd4, 32'h104);
    sb.push_back('{rd: 5'd3, data: 32'h103}); sb.push_back('{rd: 5'd4, data: 32'h104});
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready_four got=%0b want=0", in_ready); end
    set_in(1, 5'd5, 32'h105, 1, 5'd6, 32'h106);
    tick();
    checks++; if ({in_ready, ctrl_writeEnable_a, ctrl_writeEnable_b} !== 3'b000) begin errors++; $display("FAIL full_hold got=%b want=000", {in_ready, ctrl_writeEnable_a, ctrl_writeEnable_b}); end
    set_in(0, 0, 0, 0, 0, 0);
    drain_en = 1'b1;
    #1;
    for (int c = 0; c < 2; c++) begin
      ea = sb.pop_front(); eb = sb.pop_front();
      checks++; if ({ctrl_writeEnable_a, ctrl_writeEnable_b} !== 2'b11) begin errors++; $display("FAIL full_drain_we[%0d] got=%b want=11", c, {ctrl_writeEnable_a, ctrl_writeEnable_b}); end
      checks++; if ({ctrl_writeReg_a, data_writeReg_a} !== {ea.rd, ea.data}) begin errors++; $display("FAIL full_drain_a[%0d] got=%0d/%h want=%0d/%h", c, ctrl_writeReg_a, data_writeReg_a, ea.rd, ea.data); end
      checks++; if ({ctrl_writeReg_b, data_writeReg_b} !== {eb.rd, eb.data}) begin errors++; $display("FAIL full_drain_b[%0d] got=%0d/%h want=%0d/%h", c, ctrl_writeReg_b, data_writeReg_b, eb.rd, eb.data); end
      tick();
    end
    checks++; if ({in_ready, ctrl_writeEnable_a, ctrl_writeEnable_b} !== 3'b100) begin errors++; $display("FAIL full_drained got=%b want=100", {in_ready, ctrl_writeEnable_a, ctrl_writeEnable_b}); end
  endtask

  task automatic test_same_rd();
    drain_en = 1'b1;
    set_in(1, 5'd5, 32'hA, 1, 5'd5, 32'hB);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    checks++; if ({ctrl_writeEnable_a, ctrl_writeEnable_b} !== 2'b01) begin errors++; $display("FAIL same_rd_we got=%b want=01", {ctrl_writeEnable_a, ctrl_writeEnable_b}); end
    checks++; if ({ctrl_writeReg_b, data_writeReg_b} !== {5'd5, 32'hB}) begin errors++; $display("FAIL same_rd_port_b got=%0d/%h want=5/b", ctrl_writeReg_b, data_writeReg_b); end
    tick();
    checks++; if ({ctrl_writeEnable_a, ctrl_writeEnable_b, ctrl_writeReg_a} !== '0) begin errors++; $display("FAIL same_rd_popped got=%b/%0d want=00/0", {ctrl_writeEnable_a, ctrl_writeEnable_b}, ctrl_writeReg_a); end
  endtask

  task automatic test_rd_zero();
    drain_en = 1'b0;
    set_in(1, 5'd0, 32'h1, 1, 5'd7, 32'h2);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    drain_en = 1'b1;
    #1;
    checks++; if ({ctrl_writeEnable_a, ctrl_writeEnable_b} !== 2'b10) begin errors++; $display("FAIL rd0_we got=%b want=10", {ctrl_writeEnable_a, ctrl_writeEnable_b}); end
    checks++; if ({ctrl_writeReg_a, data_writeReg_a} !== {5'd7, 32'h2}) begin errors++; $display("FAIL rd0_port_a got=%0d/%h want=7/2", ctrl_writeReg_a, data_writeReg_a); end
    checks++; if ({ctrl_writeReg_b, data_writeReg_b} !== '0) begin errors++; $display("FAIL rd0_port_b got=%0d/%h want=0/0", ctrl_writeReg_b, data_writeReg_b); end
    tick();
    checks++; if (ctrl_writeEnable_a !== 1'b0) begin errors++; $display("FAIL rd0_popped got=%0b want=0", ctrl_writeEnable_a); end
  endtask

  task automatic test_bypass();
    logic        exp_hit;
    logic [31:0] exp_data;
    drain_en = 1'b0;
    set_in(1, 5'd9, 32'h1, 1, 5'd9, 32'h2);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    byp_addr_0 = 5'd9; byp_addr_1 = 5'd0; byp_addr_2 = 5'd4; byp_addr_3 = 5'd9;
    #1;
`ifdef WBQ_BYPASS_EN
    exp_hit = 1'b1; exp_data = 32'h2;
`else
    exp_hit = 1'b0; exp_data = 32'h0;
`endif
    checks++; if ({byp_hit_0, byp_data_0} !== {exp_hit, exp_data}) begin errors++; $display("FAIL byp_youngest got=%0b/%h want=%0b/%h", byp_hit_0, byp_data_0, exp_hit, exp_data); end
    checks++; if ({byp_hit_3, byp_data_3} !== {exp_hit, exp_data}) begin errors++; $display("FAIL byp_port3 got=%0b/%h want=%0b/%h", byp_hit_3, byp_data_3, exp_hit, exp_data); end
    checks++; if ({byp_hit_1, byp_hit_2, byp_data_1, byp_data_2} !== '0) begin errors++; $display("FAIL byp_miss got=%b want=00", {byp_hit_1, byp_hit_2}); end
    drain_en = 1'b1;
    tick();
    checks++; if (byp_hit_0 !== 1'b0) begin errors++; $display("FAIL byp_after_drain got=%0b want=0", byp_hit_0); end
    byp_addr_0 = 0; byp_addr_3 = 0; byp_addr_2 = 0;
  endtask

  task automatic test_reset_mid();
    drain_en = 1'b0;
    set_in(1, 5'd10, 32'hA0, 1, 5'd11, 32'hB0);
    tick();
    set_in(1, 5'd12, 32'hC0, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_three_ready got=%0b want=0", in_ready); end
    ctrl_reset = 1'b0;
    tick();
    ctrl_reset = 1'b1;
    drain_en = 1'b1;
    #1;
    checks++; if ({ctrl_writeEnable_a, ctrl_writeEnable_b} !== 2'b00) begin errors++; $display("FAIL mid_reset_we got=%b want=00", {ctrl_writeEnable_a, ctrl_writeEnable_b}); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready got=%0b want=1", in_ready); end
  endtask

  // Random traffic with concurrent push/pop; sb holds queued entries in age order.
  task automatic test_back_to_back();
    logic exp_ready, exp_we_a, exp_we_b;
    int   pops;
    sb.delete();
    for (int c = 0; c < 80; c++) begin
      set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      drain_en = ($urandom_range(0, 3) != 0);
      #1;
      exp_ready = ((DEPTH - sb.size()) >= 2);
      exp_we_b  = drain_en && (sb.size() >= 2);
      exp_we_a  = drain_en && (sb.size() >= 1) && !((sb.size() >= 2) && (sb[0].rd == sb[1].rd));
      checks++; if (in_ready !== exp_ready) begin errors++; $display("FAIL b2b_ready[%0d] got=%0b want=%0b", c, in_ready, exp_ready); end
      checks++; if ({ctrl_writeEnable_a, ctrl_writeEnable_b} !== {exp_we_a, exp_we_b}) begin errors++; $display("FAIL b2b_we[%0d] got=%b want=%b", c, {ctrl_writeEnable_a, ctrl_writeEnable_b}, {exp_we_a, exp_we_b}); end
      if (exp_we_a) begin
        checks++; if ({ctrl_writeReg_a, data_writeReg_a} !== {sb[0].rd, sb[0].data}) begin errors++; $display("FAIL b2b_port_a[%0d] got=%0d/%h want=%0d/%h", c, ctrl_writeReg_a, data_writeReg_a, sb[0].rd, sb[0].data); end
      end
      if (exp_we_b) begin
        checks++; if ({ctrl_writeReg_b, data_writeReg_b} !== {sb[1].rd, sb[1].data}) begin errors++; $display("FAIL b2b_port_b[%0d] got=%0d/%h want=%0d/%h", c, ctrl_writeReg_b, data_writeReg_b, sb[1].rd, sb[1].data); end
      end
      pops = drain_en ? ((sb.size() >= 2) ? 2 : sb.size()) : 0;
      @(posedge clock);
      for (int p = 0; p < pops; p++) void'(sb.pop_front());
      if (exp_ready && in_valid_a && (in_rd_a != 0)) sb.push_back('{rd: in_rd_a, data: in_data_a});
      if (exp_ready && in_valid_b && (in_rd_b != 0)) sb.push_back('{rd: in_rd_b, data: in_data_b});
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_dual_push();
    test_full();
    test_same_rd();
    test_rd_zero();
    test_bypass();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
